// File: rtl/dmem_lsu_if.sv
// Datapath <-> load/store unit request/response bundle.
//   master: datapath side, drives mem_read/mem_write/funct3/addr/wdata and
//           receives rdata/stall/done/misaligned.
//   slave : LSU side (dmem_lsu).
interface dmem_lsu_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        misaligned;

  modport master (
    output mem_read, mem_write, funct3, addr, wdata,
    input  rdata, stall, done, misaligned
  );

  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata,
    output rdata, stall, done, misaligned
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit with a private word-organised data memory and a fixed
// multi-cycle access latency. Stalls the datapath while an access is in flight.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - dmem_lsu_if.slave: request (mem_read, mem_write, funct3, addr, wdata)
//          and response (rdata registered, done registered, stall and
//          misaligned combinational)
// Parameters:
//   ADDR_WORDS_LOG2 - memory depth is 2^ADDR_WORDS_LOG2 32-bit words
//   LATENCY         - BUSY cycles per access, 1..15
module dmem_lsu #(
  parameter int unsigned ADDR_WORDS_LOG2 = 10,
  parameter int unsigned LATENCY         = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_lsu_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WORDS_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = ADDR_WORDS_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       f3_q, f3_d;
  logic             store_q, store_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;

  logic [31:0]      mem_q [DEPTH];

  logic             req_c;
  logic             is_half_c;
  logic             is_word_c;
  logic             misaligned_c;
  logic             fire_c;
  logic             we_c;
  logic [IDX_W-1:0] idx_c;
  logic [31:0]      word_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [31:0]      load_c;
  logic [3:0]       be_c;
  logic [31:0]      wlane_c;

  // Alignment check on the live request; 101 is only a halfword for loads.
  always_comb begin
    req_c        = bus.mem_read | bus.mem_write;
    is_half_c    = (bus.funct3 == 3'b001) | ((bus.funct3 == 3'b101) & ~bus.mem_write);
    is_word_c    = (bus.funct3 == 3'b010);
    misaligned_c = req_c & ((is_half_c & bus.addr[0]) |
                            (is_word_c & (bus.addr[1:0] != 2'b00)));
  end

  // Access happens on the last BUSY edge; high address bits wrap.
  always_comb begin
    fire_c = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));
    we_c   = fire_c & store_q;
    idx_c  = addr_q[ADDR_WORDS_LOG2+1:2];
    word_c = mem_q[idx_c];
  end

  // Load lane select and extension (little-endian lanes).
  always_comb begin
    byte_c = 8'(word_c >> {addr_q[1:0], 3'b000});
    half_c = addr_q[1] ? word_c[31:16] : word_c[15:0];
    case (f3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b010:  load_c = word_c;
      3'b100:  load_c = {24'd0, byte_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = 32'd0;
    endcase
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be_c    = 4'b0000;
    wlane_c = wdata_q;
    case (f3_q)
      3'b000: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wlane_c = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        be_c    = 4'b1111;
        wlane_c = wdata_q;
      end
      default: be_c = 4'b0000;
    endcase
  end

  // Data memory: not reset; reset only blocks the write via the FSM state.
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int k = 0; k < 4; k++) begin
        if (be_c[k]) mem_q[idx_c][8*k +: 8] <= wlane_c[8*k +: 8];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    store_d = store_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_c && !misaligned_c) begin
          state_d = S_BUSY;
          cnt_d   = CNT_W'(LATENCY);
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          f3_d    = bus.funct3;
          store_d = bus.mem_write;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (!store_q) rdata_d = load_c;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  // stall is gated by rst so it drops at once even with a request still held.
  assign bus.stall      = ~rst & (((state_q == S_IDLE) & req_c & ~misaligned_c) |
                                  (state_q == S_BUSY));
  assign bus.done       = done_q;
  assign bus.rdata      = rdata_q;
  assign bus.misaligned = misaligned_c;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit plus data memory that sits directly downstream of the single-cycle datapath's ALU. It consumes the datapath's effective address (ALU result), store data (rs2), the MemRead/MemWrite controls and the instruction's funct3. It performs byte, halfword and word accesses with a configurable multi-cycle latency and returns sign- or zero-extended load data for the MemtoReg mux. While an access is in flight it stalls the datapath, holding the PC and the register-file write.

## Interface
- ADDR_WORDS_LOG2, default 10: memory depth is 2^ADDR_WORDS_LOG2 32-bit words.
- LATENCY, default 2: number of BUSY cycles per access. Legal range is 1..15.

- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-high reset.
- mem_read, in, 1: load request (datapath MemRead).
- mem_write, in, 1: store request (datapath MemWrite). It wins if asserted together with mem_read.
- funct3, in, 3: access size and signedness.
- addr, in, 32: byte address (ALU result).
- wdata, in, 32: store data (rs2). Byte and half stores use the low bits.
- rdata, out, 32: load result, registered.
- stall, out, 1: datapath must hold PC and suppress RegWrite while high.
- done, out, 1: one-cycle pulse marking the completion cycle.
- misaligned, out, 1: combinational. The current request is misaligned and is rejected.

## Operation
- FSM states:
  - IDLE:
    - A request (mem_read or mem_write) that is aligned is accepted.
    - On acceptance, addr, wdata, funct3 and op are latched, cnt is set to LATENCY, and the FSM goes to BUSY.
  - BUSY:
    - cnt decrements each cycle.
    - On the edge where cnt==1, the access is performed and the FSM goes to DONE.
  - DONE:
    - Lasts exactly one cycle, then the FSM returns to IDLE.
    - Requests are ignored in DONE; the datapath still presents the same instruction then.
- stall = (IDLE & request & ~misaligned) | BUSY.
- done = DONE.
- Alignment rules:
  - A halfword access with addr[0]=1 is misaligned.
  - A word access with addr[1:0]!=0 is misaligned.
  - A misaligned request in IDLE asserts misaligned, performs no access, does not stall, and leaves rdata unchanged.
- Word index is addr[ADDR_WORDS_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo the memory size.
- Load funct3 decoding:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Lane select uses addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
  - Any other funct3 writes rdata=0 and still completes the handshake.
- Store funct3 decoding:
  - 000 SB, 001 SH, 010 SW, using byte enables on the addressed lanes.
  - Other funct3 values write nothing and still complete the handshake.
- Byte order is little-endian: byte lane k is bits [8k+7:8k].
- rdata updates only on load completion and holds its value otherwise.
- Memory array contents are not reset; they are undefined until written.

## Timing
- Request seen in IDLE at cycle T:
  - Cycle T: stall=1.
  - Cycles T+1 .. T+LATENCY: BUSY, stall=1.
  - Cycle T+LATENCY+1: DONE, stall=0, done=1, and rdata is valid for a load.
  - The datapath commits at the end of the DONE cycle. Each memory instruction therefore occupies LATENCY+2 cycles.
- A store's write takes effect on the edge entering DONE. A load issued afterward returns the new data.
- Inputs are sampled only at acceptance. Changes during BUSY have no effect.
- Reset (asserted at any time, including mid-access):
  - state=IDLE, cnt=0, rdata=0, done=0.
  - stall goes to 0 immediately (asynchronously); misaligned follows its inputs.
  - An interrupted store does not write: the write enable is gated by reaching the cnt==1 BUSY edge.
- Back-to-back requests: a new request may be accepted in the cycle following DONE.
- A non-memory instruction (both mem_read and mem_write low) gives stall=0, with no state change.

## Test plan
- Word round trip, LATENCY=2:
  - SW with addr=0x10, wdata=0xDEADBEEF, then LW at 0x10.
  - Each access: stall high for 3 cycles, then a done pulse.
  - rdata=0xDEADBEEF in the DONE cycle.
- Sub-word loads:
  - Memory word 0x10 = 0x8070F0FF.
  - LB at 0x11 gives 0xFFFFFFF0. LBU at 0x11 gives 0x000000F0.
  - LH at 0x12 gives 0xFFFF8070. LHU at 0x12 gives 0x00008070.
- Sub-word stores:
  - Word 0x20 = 0x11223344.
  - SB at 0x23 with wdata=0xAB, then SH at 0x20 with wdata=0xCDEF.
  - LW at 0x20 returns 0xAB22CDEF.
- Misalignment:
  - LW at 0x22 and SH at 0x21.
  - Required: misaligned=1, stall=0, no done pulse, memory unchanged, rdata unchanged.
- Reset mid-store:
  - Assert rst during the first BUSY cycle of SW 0x55555555 to 0x30, after 0x30 was preloaded with 0x0.
  - Required: stall=0 and done=0 immediately.
  - A subsequent LW at 0x30 returns 0x00000000.
- Wrap-around and priority, with ADDR_WORDS_LOG2=10:
  - SW to 0x1004 with mem_read also high must be performed as a store.
  - A subsequent LW at 0x0004 returns the stored value.
